// File: rtl/sample_ram_writer.sv
// Producer end of the audio sample RAM: buffers a valid/ready sample stream in a small FIFO and
// writes it to consecutive RAM addresses, announcing every completely written frame.
module sample_ram_writer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int RAM_WORDS  = 32768,
    parameter int BASE_ADDR  = 0,
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              clr_overflow,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              RAM_WREN,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_base,
    output logic              overflow
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FCNT_W = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(RAM_WORDS - 1);
    localparam logic [FCNT_W-1:0] FLAST_C = FCNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, ADVANCE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, ready_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0]   frame_start_q, frame_start_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_in_q, ram_in_d;
    logic                ram_wren_q, ram_wren_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]   frame_base_q, frame_base_d;
    logic                push, pop, go_write;
    logic [DATA_W-1:0]   head_next;

    always_comb begin
        push = sample_valid & ready_q;
        pop  = (state_q == ADVANCE);

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = sample_in;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d    = (count_d < DEPTH_C);
        overflow_d = (sample_valid & ~ready_q) | (overflow_q & ~clr_overflow);

        // The next head may be the very sample being pushed on this edge
        head_next = (push && count_d == CNT_W'(1)) ? sample_in : fifo_mem_q[rd_ptr_d];

        state_d       = state_q;
        addr_ptr_d    = addr_ptr_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = frame_start_q;
        ram_addr_d    = ram_addr_q;
        ram_in_d      = ram_in_q;
        ram_wren_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_base_d  = frame_base_q;
        go_write      = 1'b0;

        case (state_q)
            IDLE: begin
                go_write = (count_q != '0) && enable;
            end
            WRITE: begin
                state_d = ADVANCE;
                if (frame_cnt_q == FLAST_C) begin
                    frame_done_d = 1'b1;
                    frame_base_d = frame_start_q;
                end
            end
            ADVANCE: begin
                addr_ptr_d = (addr_ptr_q == LAST_C) ? BASE_C : addr_ptr_q + ADDR_W'(1);
                if (frame_cnt_q == FLAST_C) begin
                    frame_cnt_d   = '0;
                    frame_start_d = addr_ptr_d;
                end else begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end
                go_write = (count_d != '0) && enable;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (go_write) begin
            state_d    = WRITE;
            ram_wren_d = 1'b1;
            ram_addr_d = addr_ptr_d;
            ram_in_d   = head_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b0;
            overflow_q    <= 1'b0;
            addr_ptr_q    <= BASE_C;
            frame_cnt_q   <= '0;
            frame_start_q <= BASE_C;
            ram_addr_q    <= BASE_C;
            ram_in_q      <= '0;
            ram_wren_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_base_q  <= BASE_C;
        end else begin
            state_q       <= state_d;
            fifo_mem_q    <= fifo_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            overflow_q    <= overflow_d;
            addr_ptr_q    <= addr_ptr_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            ram_addr_q    <= ram_addr_d;
            ram_in_q      <= ram_in_d;
            ram_wren_q    <= ram_wren_d;
            frame_done_q  <= frame_done_d;
            frame_base_q  <= frame_base_d;
        end
    end

    assign sample_ready = ready_q;
    assign overflow     = overflow_q;
    assign RAM_ADDR     = ram_addr_q;
    assign RAM_IN       = ram_in_q;
    assign RAM_WREN     = ram_wren_q;
    assign frame_done   = frame_done_q;
    assign frame_base   = frame_base_q;

endmodule

// File: tb/tb_sample_ram_writer.sv
// Directed bench for sample_ram_writer: a default instance plus one placed just below the top of
// the address space so a frame straddles the wrap point; both share the same stimulus.
module tb_sample_ram_writer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clr_overflow = 1'b0;

    logic        sample_ready, RAM_WREN, frame_done, overflow;
    logic [14:0] RAM_ADDR, frame_base;
    logic [15:0] RAM_IN;

    logic        w_sample_ready, w_ram_wren, w_frame_done, w_overflow;
    logic [14:0] w_ram_addr, w_frame_base;
    logic [15:0] w_ram_in;

    int compare_count = 0;
    int mismatch_count = 0;
    int cyc = 0;
    int acc_cyc;
    bit ready_low_seen = 1'b0;

    logic [14:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    logic [14:0] fb_log[$];
    int          fd_cyc[$];
    logic [14:0] w_addr[$];
    logic [14:0] w_fb[$];

    sample_ram_writer dut (
        .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .clr_overflow(clr_overflow),
        .RAM_ADDR(RAM_ADDR), .RAM_IN(RAM_IN), .RAM_WREN(RAM_WREN), .frame_done(frame_done),
        .frame_base(frame_base), .overflow(overflow)
    );

    sample_ram_writer #(.BASE_ADDR(32'h7FE8)) dut_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(w_sample_ready), .clr_overflow(clr_overflow),
        .RAM_ADDR(w_ram_addr), .RAM_IN(w_ram_in), .RAM_WREN(w_ram_wren),
        .frame_done(w_frame_done), .frame_base(w_frame_base), .overflow(w_overflow)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Log every RAM write and frame announcement mid-cycle, away from the active edge
    always @(negedge Clk) begin
        if (RAM_WREN) begin
            wr_addr.push_back(RAM_ADDR);
            wr_data.push_back(RAM_IN);
            wr_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fb_log.push_back(frame_base);
            fd_cyc.push_back(cyc);
        end
        if (w_ram_wren) w_addr.push_back(w_ram_addr);
        if (w_frame_done) w_fb.push_back(w_frame_base);
        if (!sample_ready && Reset_n) ready_low_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        fb_log.delete();
        fd_cyc.delete();
        w_addr.delete();
        w_fb.delete();
        ready_low_seen = 1'b0;
    endtask

    task automatic doReset();
        sample_valid = 1'b0;
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
    endtask

    // Offer one sample as a well-behaved producer: wait for ready, then valid for one edge
    task automatic applyStimulus(input logic [15:0] data);
        int waited = 0;
        while (sample_ready !== 1'b1 && waited < 100) begin
            tick(1);
            waited++;
        end
        if (waited >= 100) checkOutput("ready_timeout", {31'b0, sample_ready}, 32'd1);
        sample_in = data;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic waitWrites(input string tag, input int n);
        int waited = 0;
        while (wr_addr.size() < n && waited < 400) begin
            tick(1);
            waited++;
        end
        checkOutput(tag, wr_addr.size(), n);
    endtask

    initial begin
        // Reset values while Reset_n is held low
        tick(2);
        checkOutput("rst_ready", {31'b0, sample_ready}, 32'd0);
        checkOutput("rst_wren", {31'b0, RAM_WREN}, 32'd0);
        checkOutput("rst_addr", RAM_ADDR, 32'h0);
        checkOutput("rst_data", RAM_IN, 32'h0);
        checkOutput("rst_fdone", {31'b0, frame_done}, 32'd0);
        checkOutput("rst_fbase", frame_base, 32'h0);
        checkOutput("rst_ovf", {31'b0, overflow}, 32'd0);
        checkOutput("rst_waddr", w_ram_addr, 32'h7FE8);
        checkOutput("rst_wfbase", w_frame_base, 32'h7FE8);
        Reset_n = 1'b1;
        checkOutput("rel_ready_lo", {31'b0, sample_ready}, 32'd0);
        tick(1);
        checkOutput("rel_ready_hi", {31'b0, sample_ready}, 32'd1);

        // One full frame of back-to-back samples
        clearLogs();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(16'(i));
        waitWrites("t1_writes", 16);
        tick(4);
        checkOutput("t1_count", wr_addr.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr.size()) begin
                checkOutput($sformatf("t1_addr%0d", i), wr_addr[i], i);
                checkOutput($sformatf("t1_data%0d", i), wr_data[i], i);
            end
        end
        checkOutput("t1_frames", fb_log.size(), 1);
        if (fb_log.size() > 0 && wr_cyc.size() == 16) begin
            checkOutput("t1_fbase", fb_log[0], 32'h0);
            checkOutput("t1_fdone_cyc", fd_cyc[0], wr_cyc[15] + 1);
        end
        checkOutput("t1_ready_dropped", {31'b0, ready_low_seen}, 32'd1);
        checkOutput("t1_ovf", {31'b0, overflow}, 32'd0);

        // Enable low: FIFO fills, excess samples are refused and flagged
        doReset();
        enable = 1'b0;
        clearLogs();
        for (int i = 0; i < 8; i++) begin
            sample_in = 16'h0100 + 16'(i);
            sample_valid = 1'b1;
            tick(1);
        end
        sample_valid = 1'b0;
        tick(3);
        checkOutput("t2_no_wren", wr_addr.size(), 0);
        checkOutput("t2_ready_lo", {31'b0, sample_ready}, 32'd0);
        checkOutput("t2_ovf", {31'b0, overflow}, 32'd1);
        enable = 1'b1;
        waitWrites("t2_writes", 4);
        tick(10);
        checkOutput("t2_count", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) begin
                checkOutput($sformatf("t2_addr%0d", i), wr_addr[i], i);
                checkOutput($sformatf("t2_data%0d", i), wr_data[i], 32'h100 + i);
            end
        end
        checkOutput("t2_no_frame", fb_log.size(), 0);
        checkOutput("t2_ready_hi", {31'b0, sample_ready}, 32'd1);

        // Overflow clear alone, then set and clear on the same edge
        enable = 1'b0;
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checkOutput("t4_clr", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0200 + 16'(i));
        checkOutput("t4_full", {31'b0, sample_ready}, 32'd0);
        sample_valid = 1'b1;
        clr_overflow = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        clr_overflow = 1'b0;
        checkOutput("t4_set_wins", {31'b0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checkOutput("t4_clr2", {31'b0, overflow}, 32'd0);
        enable = 1'b1;
        tick(20);
        checkOutput("t4_drained", wr_addr.size(), 8);
        if (wr_addr.size() == 8) begin
            checkOutput("t4_last_addr", wr_addr[7], 32'd7);
            checkOutput("t4_last_data", wr_data[7], 32'h203);
        end

        // Two frames: the offset instance straddles the wrap point on its second frame
        doReset();
        clearLogs();
        for (int i = 0; i < 32; i++) applyStimulus(16'h0300 + 16'(i));
        waitWrites("t3_writes", 32);
        tick(5);
        checkOutput("t3_wcount", w_addr.size(), 32);
        if (w_addr.size() == 32) begin
            checkOutput("t3_w0", w_addr[0], 32'h7FE8);
            checkOutput("t3_w15", w_addr[15], 32'h7FF7);
            checkOutput("t3_w16", w_addr[16], 32'h7FF8);
            checkOutput("t3_w23", w_addr[23], 32'h7FFF);
            checkOutput("t3_w24", w_addr[24], 32'h7FE8);
            checkOutput("t3_w31", w_addr[31], 32'h7FEF);
        end
        checkOutput("t3_wframes", w_fb.size(), 2);
        if (w_fb.size() == 2) begin
            checkOutput("t3_wfb0", w_fb[0], 32'h7FE8);
            checkOutput("t3_wfb1", w_fb[1], 32'h7FF8);
        end
        checkOutput("t3_frames", fb_log.size(), 2);
        if (fb_log.size() == 2) checkOutput("t3_fb1", fb_log[1], 32'd16);

        // Reset mid-frame abandons the partial frame
        clearLogs();
        for (int i = 0; i < 9; i++) applyStimulus(16'h0400 + 16'(i));
        waitWrites("t5_pre", 9);
        tick(1);
        Reset_n = 1'b0;
        #2;
        checkOutput("t5_addr", RAM_ADDR, 32'h0);
        checkOutput("t5_data", RAM_IN, 32'h0);
        checkOutput("t5_wren", {31'b0, RAM_WREN}, 32'd0);
        checkOutput("t5_ready", {31'b0, sample_ready}, 32'd0);
        checkOutput("t5_fbase", frame_base, 32'h0);
        checkOutput("t5_wfbase", w_frame_base, 32'h7FE8);
        tick(2);
        Reset_n = 1'b1;
        tick(3);
        checkOutput("t5_no_frame", fb_log.size(), 0);
        clearLogs();
        for (int i = 0; i < 16; i++) applyStimulus(16'h0500 + 16'(i));
        waitWrites("t5_writes", 16);
        tick(4);
        if (wr_addr.size() == 16) begin
            checkOutput("t5_addr0", wr_addr[0], 32'h0);
            checkOutput("t5_addr15", wr_addr[15], 32'd15);
            checkOutput("t5_data15", wr_data[15], 32'h50F);
        end
        checkOutput("t5_frames", fb_log.size(), 1);
        if (fb_log.size() == 1) checkOutput("t5_fb0", fb_log[0], 32'h0);

        // Single sample into an idle block: latency and single-cycle strobe
        tick(3);
        clearLogs();
        applyStimulus(16'h0ABC);
        acc_cyc = cyc;
        tick(8);
        checkOutput("t6_count", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) begin
            checkOutput("t6_latency", wr_cyc[0] - acc_cyc, 32'd1);
            checkOutput("t6_addr", wr_addr[0], 32'd16);
        end
        checkOutput("t6_wren_lo", {31'b0, RAM_WREN}, 32'd0);
        checkOutput("t6_hold_addr", RAM_ADDR, 32'd16);
        checkOutput("t6_hold_data", RAM_IN, 32'h0ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
